// File: rtl/cgra_pkg.sv
// Shared STRELA CGRA definitions: node counts, execution-controller states and
// a helper that turns per-node output sizes into an active-node mask.
package cgra_pkg;

  localparam int INPUT_NODES  = 4;
  localparam int OUTPUT_NODES = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    EXEC,
    DONE
  } ctrl_state_t;

  // A node takes part in a run only when it has something to produce
  function automatic logic [OUTPUT_NODES-1:0] active_mask(
    input logic [16*OUTPUT_NODES-1:0] sizes
  );
    logic [OUTPUT_NODES-1:0] mask;
    for (int n = 0; n < OUTPUT_NODES; n++) begin
      mask[n] = (sizes[16*n +: 16] != 16'd0);
    end
    return mask;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Saturating performance counter: clear wins over enable, and the count
// sticks at all-ones instead of wrapping.
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// STRELA execution controller: sequences optional bitstream clear, bitstream
// load and kernel execution from CSR pulses, and keeps the run's cycle counters.
module exec_ctrl
  import cgra_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         clear_bs_i,
  input  logic                         change_bs_i,
  input  logic [15:0]                  config_size_i,
  input  logic [16*OUTPUT_NODES-1:0]   output_size_i,
  input  logic                         cfg_word_i,
  input  logic [OUTPUT_NODES-1:0]      out_done_i,
  input  logic                         stall_i,
  output logic                         execute_o,
  output logic                         clear_bs_o,
  output logic                         cfg_load_o,
  output logic                         exec_start_o,
  output logic                         done_o,
  output logic [31:0]                  bs_cycles_o,
  output logic [31:0]                  exec_cycles_o,
  output logic [31:0]                  stall_cycles_o
);

  ctrl_state_t             state, state_next;
  logic                    bs_valid, bs_valid_next;
  logic                    pending_start, pending_start_next;
  logic [15:0]             cfg_size, cfg_size_next;
  logic [15:0]             word_cnt, word_cnt_next;
  logic [OUTPUT_NODES-1:0] mask, mask_next;
  logic [OUTPUT_NODES-1:0] done_bits, done_bits_next;
  logic                    exec_seen;
  logic                    counter_clear;
  logic                    in_load, in_exec, in_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      bs_valid      <= 1'b0;
      pending_start <= 1'b0;
      cfg_size      <= '0;
      word_cnt      <= '0;
      mask          <= '0;
      done_bits     <= '0;
      exec_seen     <= 1'b0;
    end else begin
      state         <= state_next;
      bs_valid      <= bs_valid_next;
      pending_start <= pending_start_next;
      cfg_size      <= cfg_size_next;
      word_cnt      <= word_cnt_next;
      mask          <= mask_next;
      done_bits     <= done_bits_next;
      exec_seen     <= (state == EXEC);
    end
  end

  always_comb begin
    state_next         = state;
    bs_valid_next      = bs_valid;
    pending_start_next = pending_start;
    cfg_size_next      = cfg_size;
    word_cnt_next      = word_cnt;
    mask_next          = mask;
    done_bits_next     = done_bits;
    counter_clear      = 1'b0;

    unique case (state)
      IDLE: begin
        // Run parameters are captured once so CSR edits mid-run cannot leak in
        if (start_i) begin
          cfg_size_next = config_size_i;
          mask_next     = active_mask(output_size_i);
          word_cnt_next = '0;
          counter_clear = 1'b1;
        end
        if (clear_bs_i) begin
          state_next         = CLEAR;
          pending_start_next = start_i;
        end else if (start_i && (change_bs_i || !bs_valid) && (config_size_i != 16'd0)) begin
          state_next = LOAD;
        end else if (start_i) begin
          state_next = EXEC;
        end
      end
      CLEAR: begin
        bs_valid_next      = 1'b0;
        pending_start_next = 1'b0;
        if (pending_start) begin
          state_next = (cfg_size != 16'd0) ? LOAD : EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (cfg_word_i) begin
          word_cnt_next = word_cnt + 16'd1;
          if ((word_cnt + 16'd1) == cfg_size) begin
            bs_valid_next = 1'b1;
            state_next    = EXEC;
          end
        end
      end
      EXEC: begin
        // A node finishing in the same cycle as the last one still counts
        done_bits_next = done_bits | (out_done_i & mask);
        if (((done_bits | out_done_i) & mask) == mask) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_bits_next = '0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign execute_o    = (state != IDLE);
  assign clear_bs_o   = (state == CLEAR);
  assign cfg_load_o   = (state == LOAD);
  assign exec_start_o = (state == EXEC) && !exec_seen;
  assign done_o       = (state == DONE);

  assign in_load  = (state == LOAD);
  assign in_exec  = (state == EXEC);
  assign in_stall = in_exec && stall_i;

  perf_counter #(.WIDTH(32)) u_bs_cycles (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (counter_clear),
    .enable (in_load),
    .count  (bs_cycles_o)
  );

  perf_counter #(.WIDTH(32)) u_exec_cycles (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (counter_clear),
    .enable (in_exec),
    .count  (exec_cycles_o)
  );

  perf_counter #(.WIDTH(32)) u_stall_cycles (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (counter_clear),
    .enable (in_stall),
    .count  (stall_cycles_o)
  );

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: table of whole runs with end-of-run counter records
// checked from a queue when done_o fires, plus clear-only, reset-abort and saturation cases.
module tb_exec_ctrl;
  import cgra_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, clear_bs_i, change_bs_i, cfg_word_i, stall_i;
  logic [15:0] config_size_i;
  logic [63:0] output_size_i;
  logic [3:0]  out_done_i;
  logic        execute_o, clear_bs_o, cfg_load_o, exec_start_o, done_o;
  logic [31:0] bs_cycles_o, exec_cycles_o, stall_cycles_o;
  logic        satClear, satEn;
  logic [2:0]  satCount;

  typedef struct {
    logic        clr;
    logic        chg;
    logic [15:0] size;
    logic [3:0]  mask;
    int          gap;
    int          firstDone;
    int          lastDone;
    int          stallLen;
    logic        expClr;
    logic        expLoad;
    int          expBs;
    int          expExec;
    int          expStall;
  } vec_t;

  typedef struct {
    int bs;
    int exec;
    int stall;
  } rec_t;

  rec_t expQ[$];
  vec_t vecs[9];
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk_i = ~clk_i;

  exec_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .clear_bs_i     (clear_bs_i),
    .change_bs_i    (change_bs_i),
    .config_size_i  (config_size_i),
    .output_size_i  (output_size_i),
    .cfg_word_i     (cfg_word_i),
    .out_done_i     (out_done_i),
    .stall_i        (stall_i),
    .execute_o      (execute_o),
    .clear_bs_o     (clear_bs_o),
    .cfg_load_o     (cfg_load_o),
    .exec_start_o   (exec_start_o),
    .done_o         (done_o),
    .bs_cycles_o    (bs_cycles_o),
    .exec_cycles_o  (exec_cycles_o),
    .stall_cycles_o (stall_cycles_o)
  );

  perf_counter #(.WIDTH(3)) satCnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (satClear),
    .enable (satEn),
    .count  (satCount)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  // Counter values at the done pulse must match the record queued at run start
  always @(negedge clk_i) begin : monitor
    rec_t r;
    if (done_o === 1'b1) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpectedDone: got done_o=1 expected 0");
      end else begin
        r = expQ.pop_front();
        checkOutput("bsCyclesAtDone", bs_cycles_o, r.bs);
        checkOutput("execCyclesAtDone", exec_cycles_o, r.exec);
        checkOutput("stallCyclesAtDone", stall_cycles_o, r.stall);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    logic [63:0] osz;
    logic [3:0]  others;
    int          hi;
    osz = '0;
    hi  = -1;
    for (int n = 0; n < 4; n++) begin
      if (v.mask[n]) begin
        osz[16*n +: 16] = 16'h0008 << (4*n);
        hi = n;
      end
    end
    others = v.mask;
    if (hi >= 0) others[hi] = 1'b0;

    start_i       = 1'b1;
    clear_bs_i    = v.clr;
    change_bs_i   = v.chg;
    config_size_i = v.size;
    output_size_i = osz;
    step();
    start_i       = 1'b0;
    clear_bs_i    = 1'b0;
    change_bs_i   = 1'b0;
    config_size_i = 16'hFFFF;
    output_size_i = '1;
    checkOutput("busyAfterStart", execute_o, 1);
    checkOutput("bsClearedAtStart", bs_cycles_o, 0);
    checkOutput("execClearedAtStart", exec_cycles_o, 0);
    checkOutput("clearPulse", clear_bs_o, v.expClr);
    if (v.expClr) begin
      checkOutput("noLoadDuringClear", cfg_load_o, 0);
      step();
    end

    if (v.expLoad) begin
      for (int w = 0; w < int'(v.size); w++) begin
        for (int g = 0; g < v.gap; g++) begin
          cfg_word_i = 1'b0;
          out_done_i = 4'hF;
          checkOutput("cfgLoadGap", cfg_load_o, 1);
          step();
        end
        cfg_word_i = 1'b1;
        out_done_i = 4'hF;
        checkOutput("cfgLoadWord", cfg_load_o, 1);
        step();
      end
      cfg_word_i = 1'b0;
      out_done_i = 4'h0;
    end
    checkOutput("notLoading", cfg_load_o, 0);

    expQ.push_back('{bs: v.expBs, exec: v.expExec, stall: v.expStall});
    for (int c = 0; c <= v.lastDone; c++) begin
      checkOutput("execStart", exec_start_o, (c == 0));
      checkOutput("noEarlyDone", done_o, 0);
      stall_i    = (c < v.stallLen);
      out_done_i = ~v.mask;
      if (c == v.firstDone && hi >= 0) out_done_i[hi] = 1'b1;
      if (c == v.lastDone) out_done_i = out_done_i | others;
      step();
    end
    stall_i    = 1'b0;
    out_done_i = 4'h0;
    checkOutput("doneTiming", done_o, 1);
    checkOutput("busyDuringDone", execute_o, 1);
    step();
    checkOutput("idleAfterDone", execute_o, 0);
    checkOutput("doneOnePulse", done_o, 0);
    checkOutput("bsHeld", bs_cycles_o, v.expBs);
    checkOutput("execHeld", exec_cycles_o, v.expExec);
    checkOutput("stallHeld", stall_cycles_o, v.expStall);
  endtask

  task automatic clearOnly(input int bs, input int ex, input int st);
    clear_bs_i = 1'b1;
    step();
    clear_bs_i = 1'b0;
    checkOutput("clearOnlyPulse", clear_bs_o, 1);
    checkOutput("clearOnlyBusy", execute_o, 1);
    checkOutput("clearOnlyNoLoad", cfg_load_o, 0);
    step();
    checkOutput("clearOnlyIdle", execute_o, 0);
    checkOutput("clearOnlyNoStart", exec_start_o, 0);
    checkOutput("clearOnlyBsHeld", bs_cycles_o, bs);
    checkOutput("clearOnlyExecHeld", exec_cycles_o, ex);
    checkOutput("clearOnlyStallHeld", stall_cycles_o, st);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'd3, 4'b0001, 1, 2, 2, 1, 1'b0, 1'b1, 6, 3, 1};
    vecs[1] = '{1'b0, 1'b0, 16'd3, 4'b0001, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1, 0};
    vecs[2] = '{1'b0, 1'b1, 16'd2, 4'b0011, 0, 1, 3, 2, 1'b0, 1'b1, 2, 4, 2};
    vecs[3] = '{1'b0, 1'b0, 16'd5, 4'b0101, 0, 2, 6, 4, 1'b0, 1'b0, 0, 7, 4};
    vecs[4] = '{1'b0, 1'b0, 16'd1, 4'b0000, 0, 0, 0, 3, 1'b0, 1'b0, 0, 1, 1};
    vecs[5] = '{1'b1, 1'b0, 16'd2, 4'b1000, 0, 1, 1, 0, 1'b1, 1'b1, 2, 2, 0};
    vecs[6] = '{1'b1, 1'b0, 16'd0, 4'b0001, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1, 0};
    vecs[7] = '{1'b0, 1'b0, 16'd2, 4'b0001, 2, 0, 0, 0, 1'b0, 1'b1, 6, 1, 0};
    vecs[8] = '{1'b0, 1'b0, 16'd1, 4'b0010, 0, 1, 1, 0, 1'b0, 1'b1, 1, 2, 0};

    rst_ni        = 1'b0;
    start_i       = 1'b0;
    clear_bs_i    = 1'b0;
    change_bs_i   = 1'b0;
    cfg_word_i    = 1'b0;
    stall_i       = 1'b0;
    config_size_i = '0;
    output_size_i = '0;
    out_done_i    = '0;
    satClear      = 1'b0;
    satEn         = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
    step();
    checkOutput("resetExecute", execute_o, 0);
    checkOutput("resetClear", clear_bs_o, 0);
    checkOutput("resetLoad", cfg_load_o, 0);
    checkOutput("resetStart", exec_start_o, 0);
    checkOutput("resetDone", done_o, 0);
    checkOutput("resetBs", bs_cycles_o, 0);
    checkOutput("resetExec", exec_cycles_o, 0);
    checkOutput("resetStall", stall_cycles_o, 0);

    // Saturation on a narrow instance of the same counter
    satEn = 1'b1;
    repeat (3) step();
    checkOutput("satCounting", satCount, 3);
    repeat (7) step();
    checkOutput("satHoldsMax", satCount, 7);
    satEn    = 1'b0;
    satClear = 1'b1;
    step();
    satClear = 1'b0;
    checkOutput("satCleared", satCount, 0);

    for (int i = 0; i < 8; i++) begin
      if (i == 2) clearOnly(0, 1, 0);
      applyStimulus(vecs[i]);
    end

    // Reset mid-EXEC: immediate abort, no done, bitstream forgotten
    start_i       = 1'b1;
    change_bs_i   = 1'b1;
    config_size_i = 16'd1;
    output_size_i = 64'h0000_0000_0000_0008;
    step();
    start_i     = 1'b0;
    change_bs_i = 1'b0;
    checkOutput("abortLoad", cfg_load_o, 1);
    cfg_word_i = 1'b1;
    step();
    cfg_word_i = 1'b0;
    checkOutput("abortExecStart", exec_start_o, 1);
    stall_i = 1'b1;
    step();
    rst_ni = 1'b0;
    #1;
    checkOutput("abortExecuteLow", execute_o, 0);
    checkOutput("abortNoDone", done_o, 0);
    checkOutput("abortExecCleared", exec_cycles_o, 0);
    stall_i = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    repeat (2) step();
    checkOutput("abortStaysIdle", execute_o, 0);
    applyStimulus(vecs[8]);

    repeat (3) step();
    checkOutput("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller for the STRELA CGRA. Consumes the one-cycle control pulses and size fields from the CSR block, then sequences optional bitstream clear, bitstream load and kernel execution. It drives the `execute` level back to the CSR block, which locks register writes while it is high, and produces the three performance counters the CSR block reads back. The block sits between the CSR block and the configuration loader / stream nodes.

## Interface
- INPUT_NODES, 4, number of input stream nodes (from cgra_pkg)
- OUTPUT_NODES, 4, number of output stream nodes (from cgra_pkg)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse from CSR control bit 0
- clear_bs_i  in  1  clear-bitstream pulse from CSR control bit 1
- change_bs_i  in  1  force-reload pulse from CSR control bit 2
- config_size_i  in  16  bitstream length in words
- output_size_i  in  16×OUTPUT_NODES  per-node output size; 0 = node unused
- cfg_word_i  in  1  one bitstream word accepted by the fabric this cycle
- out_done_i  in  OUTPUT_NODES  per-node completion pulse
- stall_i  in  1  datapath stalled this cycle
- execute_o  out  1  busy level; goes to CSR `execute_i`
- clear_bs_o  out  1  one-cycle fabric configuration clear
- cfg_load_o  out  1  level, configuration loader active
- exec_start_o  out  1  one-cycle stream-node start
- done_o  out  1  one-cycle completion, usable as interrupt
- bs_cycles_o, exec_cycles_o, stall_cycles_o  out  32 each  performance counters

## Operation
- States: IDLE, CLEAR, LOAD, EXEC, DONE. Internal flag bs_valid means a bitstream is resident.
- IDLE transitions, in priority order:
  - clear_bs_i → CLEAR.
  - Otherwise, start_i with (change_bs_i or !bs_valid) and latched size ≠ 0 → LOAD.
  - Otherwise, start_i → EXEC. This covers a resident bitstream and a size-0 load skip.
- CLEAR lasts 1 cycle. It asserts clear_bs_o and sets bs_valid=0.
  - If start_i was accepted together with clear_bs_i, the start is remembered and CLEAR goes to LOAD. A size of 0 goes to EXEC instead.
  - A clear with no start returns to IDLE.
- On start acceptance, latch:
  - config_size_i;
  - the active mask, bit n = (output_size_i[n] ≠ 0);
  - zero to all three counters.
- LOAD:
  - cfg_load_o=1.
  - A 16-bit word counter increments on cfg_word_i.
  - The cfg_word_i that brings the count to the latched size sets bs_valid=1 and moves to EXEC.
- EXEC:
  - exec_start_o pulses on the first EXEC cycle.
  - Per-node done bits accumulate from out_done_i, masked to active nodes.
  - When (done_bits | out_done_i) ⊇ active mask → DONE.
  - An empty active mask → DONE after exactly 1 EXEC cycle.
- DONE lasts 1 cycle: done_o=1, clear the done bits, → IDLE.
- execute_o = (state ≠ IDLE).
- control pulses arriving outside IDLE are ignored; the CSR block already blocks them.
- Counters:
  - bs_cycles counts cycles in LOAD.
  - exec_cycles counts cycles in EXEC.
  - stall_cycles counts EXEC cycles with stall_i=1.
  - All saturate at 0xFFFFFFFF and hold their values in IDLE until the next start.
- out_done_i for inactive nodes, or outside EXEC, is ignored.

## Timing
- Reset values: state=IDLE, bs_valid=0, all outputs 0, all counters 0.
- Asynchronous reset mid-LOAD or mid-EXEC aborts immediately. No done_o is issued.
- start_i sampled at cycle t:
  - state, execute_o and cfg_load_o (or exec_start_o) are valid at t+1.
  - counters read 0 at t+1.
- Final cfg_word_i at cycle t → EXEC and exec_start_o at t+1.
- Completing out_done_i at cycle t → done_o at t+1 and execute_o low at t+2.
- start_i and clear_bs_i in the same cycle → clear_bs_o at t+1, cfg_load_o at t+2.
- Minimum start-to-done with a resident bitstream and an empty active mask: done_o at t+2.

## Structure
- `ctrl_state_t` enum, INPUT_NODES and OUTPUT_NODES belong in cgra_pkg.
- One sub-module, `perf_counter`: 32-bit saturating counter with clear and enable inputs, instantiated three times.

## Test plan
- config_size=3, bs_valid=0, start: cfg_load_o for exactly 3 accepted words spaced by gaps → exec_start_o 1 cycle after the third word, bs_cycles equals cycles spent in LOAD.
- Second start without change_bs: no LOAD, exec_start_o at t+1, bs_cycles=0. A third start with change_bs=1 reloads.
- Active mask 0b0101, out_done_i[2] at cycle 10 and [0] at cycle 14, stall_i high for 4 EXEC cycles → done_o at 15, stall_cycles=4, out_done_i[1] ignored.
- Simultaneous start+clear_bs with config_size=2 → clear_bs_o at t+1, LOAD from t+2, done_o after outputs complete. Size 0 → EXEC at t+2 with no LOAD.
- All output sizes 0 with bs resident → done_o at t+2. Counter forced near 0xFFFFFFFF saturates and does not wrap.
- rst_ni pulsed mid-EXEC → execute_o=0 immediately, no done_o, next start reloads the bitstream because bs_valid=0.
